alu_seq: RTL and testbench

//   Parametrised multi-cycle ALU: add, subtract, shift-add multiply and restoring

---
 rtl/alu_seq.sv | 214 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: add, subtract (magnitude + sign), shift-add multiply and
// restoring divide, with a start/busy/done handshake and registered results.
module alu_seq #(
    parameter int unsigned WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   portA,
    input  logic [WIDTH-1:0]   portB,
    input  logic [1:0]         opcode,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               signo,
    output logic               div0
);

    localparam int unsigned RW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StAddSub,
        StMul,
        StDiv,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RW-1:0]    result_q, result_d;
    logic             signo_q, signo_d;
    logic             div0_q, div0_d;

    // Datapath helpers
    logic [WIDTH:0]   sum;
    logic             a_ge_b;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   part;
    logic             fits;
    logic [WIDTH-1:0] trial;

    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        a_ge_b = (a_q >= b_q);
        diff   = a_ge_b ? (a_q - b_q) : (b_q - a_q);
        // Divide works on {remainder, quotient} packed in acc; part is the shifted remainder.
        part   = acc_q[RW-1:WIDTH-1];
        fits   = (part >= {1'b0, b_q});
        trial  = part[WIDTH-1:0] - b_q;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        signo_d  = signo_q;
        div0_d   = div0_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = portA;
                    b_d     = portB;
                    sub_d   = opcode[0];
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    dz_d    = 1'b0;
                    mcand_d = {{WIDTH{1'b0}}, portA};
                    mplr_d  = portB;
                    unique case (opcode)
                        2'b10: begin
                            acc_d   = '0;
                            state_d = StMul;
                        end
                        2'b11: begin
                            acc_d   = {{WIDTH{1'b0}}, portA};
                            state_d = StDiv;
                        end
                        default: begin
                            acc_d   = '0;
                            state_d = StAddSub;
                        end
                    endcase
                end
            end

            StAddSub: begin
                if (sub_q) begin
                    acc_d = {{WIDTH{1'b0}}, diff};
                    neg_d = ~a_ge_b;
                end else begin
                    acc_d = {{(WIDTH-1){1'b0}}, sum};
                    neg_d = 1'b0;
                end
                state_d = StFin;
            end

            StMul: begin
                // Iterations at cnt 0..WIDTH-1; the cnt==WIDTH cycle hands over to FIN.
                if (cnt_q == CntLast) begin
                    state_d = StFin;
                end else begin
                    if (mplr_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            StDiv: begin
                if (b_q == '0) begin
                    acc_d   = {a_q, {WIDTH{1'b1}}};
                    dz_d    = 1'b1;
                    state_d = StFin;
                end else if (cnt_q == CntLast) begin
                    state_d = StFin;
                end else begin
                    if (fits) begin
                        acc_d = {trial, acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[RW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StFin: begin
                result_d = acc_q;
                signo_d  = neg_q;
                div0_d   = dz_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            signo_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            signo_q  <= signo_d;
            div0_q   <= div0_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign signo  = signo_q;
    assign div0   = div0_q;

    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst) done |-> !busy);
    a_done_single:   assert property (@(posedge clk) disable iff (!rst) done |=> !done);

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq at WIDTH=3 and WIDTH=8 against an
// arithmetic reference model.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_drv;
    logic       sel;
    logic [7:0] a_drv;
    logic [7:0] b_drv;
    logic [1:0] op_drv;

    logic       start3, start8;
    logic       busy3, done3, signo3, div03;
    logic [5:0] result3;
    logic       busy8, done8, signo8, div08;
    logic [15:0] result8;

    assign start3 = start_drv & ~sel;
    assign start8 = start_drv & sel;

    alu_seq #(.WIDTH(3)) u_dut3 (
        .clk    (clk),
        .rst    (rst),
        .portA  (a_drv[2:0]),
        .portB  (b_drv[2:0]),
        .opcode (op_drv),
        .start  (start3),
        .busy   (busy3),
        .done   (done3),
        .result (result3),
        .signo  (signo3),
        .div0   (div03)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .portA  (a_drv),
        .portB  (b_drv),
        .opcode (op_drv),
        .start  (start8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .signo  (signo8),
        .div0   (div08)
    );

    logic        cur_busy, cur_done, cur_signo, cur_div0;
    logic [15:0] cur_result;
    assign cur_busy   = sel ? busy8   : busy3;
    assign cur_done   = sel ? done8   : done3;
    assign cur_signo  = sel ? signo8  : signo3;
    assign cur_div0   = sel ? div08   : div03;
    assign cur_result = sel ? result8 : {10'b0, result3};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's definition.
    task automatic model(input int w, input int op, input int a, input int b,
                         output int res, output int sg, output int dz, output int lat);
        sg  = 0;
        dz  = 0;
        lat = 2;
        case (op)
            0: res = a + b;
            1: begin
                if (a >= b) res = a - b;
                else begin
                    res = b - a;
                    sg  = 1;
                end
            end
            2: begin
                res = a * b;
                lat = w + 2;
            end
            default: begin
                if (b == 0) begin
                    res = (a << w) | ((1 << w) - 1);
                    dz  = 1;
                end else begin
                    res = ((a % b) << w) | (a / b);
                    lat = w + 2;
                end
            end
        endcase
    endtask

    task automatic run_op(input int w, input int op, input int a, input int b,
                          input bit restart, input string tag);
        int res, sg, dz, lat;
        int first, pulses;
        logic [15:0] got_res;
        logic        got_sg, got_dz;
        model(w, op, a, b, res, sg, dz, lat);
        sel     = (w == 8);
        first   = -1;
        pulses  = 0;
        got_res = '0;
        got_sg  = 1'b0;
        got_dz  = 1'b0;
        @(negedge clk);
        a_drv     = 8'(a);
        b_drv     = 8'(b);
        op_drv    = 2'(op);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        check_eq({tag, ".busy"}, 32'(cur_busy), 32'd1);
        for (int n = 1; n <= lat + 3; n++) begin
            @(posedge clk);
            #1;
            if (restart && n == 1) begin
                start_drv = 1'b1;
                a_drv     = ~a_drv;
                b_drv     = ~b_drv;
                op_drv    = 2'd0;
            end
            if (restart && n == 2) start_drv = 1'b0;
            if (cur_done) begin
                pulses++;
                if (first < 0) begin
                    first   = n;
                    got_res = cur_result;
                    got_sg  = cur_signo;
                    got_dz  = cur_div0;
                end
            end
        end
        check_eq({tag, ".lat"}, 32'(first), 32'(lat));
        check_eq({tag, ".pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, ".result"}, 32'(got_res), 32'(res));
        check_eq({tag, ".signo"}, 32'(got_sg), 32'(sg));
        check_eq({tag, ".div0"}, 32'(got_dz), 32'(dz));
        check_eq({tag, ".idle"}, 32'(cur_busy), 32'd0);
    endtask

    initial begin
        int pulses;
        rst       = 1'b0;
        start_drv = 1'b0;
        sel       = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        op_drv    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.busy3", 32'(busy3), 32'd0);
        check_eq("rst.done3", 32'(done3), 32'd0);
        check_eq("rst.result3", 32'(result3), 32'd0);
        check_eq("rst.flags3", 32'({signo3, div03}), 32'd0);
        check_eq("rst.busy8", 32'(busy8), 32'd0);
        check_eq("rst.result8", 32'(result8), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(3, 0, 7, 7, 1'b0, "w3.add77");
        run_op(3, 1, 2, 5, 1'b0, "w3.sub25");
        run_op(3, 1, 5, 5, 1'b0, "w3.sub55");
        run_op(3, 2, 7, 7, 1'b0, "w3.mul77");
        run_op(3, 2, 0, 6, 1'b0, "w3.mul06");
        run_op(3, 3, 7, 2, 1'b0, "w3.div72");
        run_op(3, 3, 5, 0, 1'b0, "w3.div50");
        run_op(3, 0, 1, 2, 1'b0, "w3.add12");
        run_op(3, 2, 6, 5, 1'b1, "w3.mulrestart");

        // Reset during the first multiply iteration aborts with no done.
        sel = 1'b0;
        @(negedge clk);
        a_drv     = 8'd7;
        b_drv     = 8'd7;
        op_drv    = 2'd2;
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst.busy", 32'(busy3), 32'd0);
        check_eq("midrst.done", 32'(done3), 32'd0);
        check_eq("midrst.result", 32'(result3), 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done3) pulses++;
        end
        check_eq("midrst.nodone", 32'(pulses), 32'd0);

        run_op(8, 0, 255, 255, 1'b0, "w8.add");
        run_op(8, 1, 3, 200, 1'b0, "w8.sub");
        run_op(8, 2, 255, 255, 1'b0, "w8.mul");
        run_op(8, 3, 200, 7, 1'b0, "w8.div");
        run_op(8, 3, 9, 0, 1'b0, "w8.div0");

        for (int i = 0; i < 30; i++) begin
            run_op(3, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 1'b0, "w3.rand");
        end
        for (int i = 0; i < 30; i++) begin
            run_op(8, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'b0, "w8.rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
